stuffed_serial_tx: RTL

//  Transmit end of the single-bit serial line w that feeds our Moore run detectors.

---
 rtl/stuffed_serial_tx.sv | 97 +++++++++
 1 files changed

// File: rtl/stuffed_serial_tx.sv
// Bit-stuffing serial transmitter: shifts a word out LSB-first on w and inserts a
// stuffed 0 after every MAX_ONES consecutive 1s so the line never exceeds that run.
`timescale 1ns/1ps
module stuffed_serial_tx #(
    parameter int WIDTH    = 8,
    parameter int MAX_ONES = 1
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             stuff,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] STUFF = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(WIDTH);
    localparam logic [2:0]    RUN_MAX  = 3'(MAX_ONES);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [2:0]       onecnt, onecnt_n;
    logic             done_r, done_n;

    always_comb begin
        state_n  = state;
        sreg_n   = sreg;
        bitcnt_n = bitcnt;
        onecnt_n = onecnt;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    sreg_n   = data_in;
                    bitcnt_n = '0;
                    onecnt_n = '0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                sreg_n   = sreg >> 1;
                bitcnt_n = bitcnt + 1'b1;
                onecnt_n = sreg[0] ? onecnt + 3'd1 : 3'd0;
                // The stuff check wins over end-of-word so a trailing run is still broken.
                if (sreg[0] && (onecnt + 3'd1 == RUN_MAX)) begin
                    state_n = STUFF;
                end else if (bitcnt == LAST_BIT) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            STUFF: begin
                onecnt_n = '0;
                if (bitcnt == ALL_BITS) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            sreg   <= '0;
            bitcnt <= '0;
            onecnt <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            bitcnt <= bitcnt_n;
            onecnt <= onecnt_n;
            done_r <= done_n;
        end
    end

    // Moore outputs decoded from registered state only.
    assign ready      = (state == IDLE);
    assign w_valid    = (state == SEND) || (state == STUFF);
    assign w          = (state == SEND) && sreg[0];
    assign stuff      = (state == STUFF);
    assign frame_done = done_r;

endmodule
